// File: rtl/dioptase_mem_pkg.sv
// Shared types and constants for the Dioptase unified-memory port arbiter.
package dioptase_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    localparam logic [BE_W-1:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_F,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory handshake signals around the arbiter.
// The master modport is the arbiter's view: it masters the memory bus and
// serves the two requesters. The slave modport is the surrounding pipeline
// and memory.
interface mem_port_arbiter_if;
    import dioptase_mem_pkg::*;

    logic              f_req;
    logic [WORD_W-1:0] f_addr;
    logic              f_flush;
    logic              f_gnt;
    logic              f_rvalid;
    logic [WORD_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        input  f_req, f_addr, f_flush,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output f_req, f_addr, f_flush,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// the memory stage. One transaction in flight at a time; data wins ties.
// Optional macro ARB_STARVE_GUARD_EN enables a starvation guard that forces
// a fetch grant after STARVE_LIMIT consecutive data grants with fetch waiting.
module mem_port_arbiter
    import dioptase_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    arb_state_t state;
    logic       drop_q;

    logic fetch_ok;
    logic force_f;
    logic pick_f;
    logic grant_f;
    logic grant_d;

    // The starve counter is 4 bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    // A flushing front end cannot win a grant on that edge.
    assign fetch_ok = bus.f_req && !bus.f_flush;
    assign pick_f   = fetch_ok && (!bus.d_req || force_f);
    assign grant_f  = (state == IDLE) && pick_f;
    assign grant_d  = (state == IDLE) && bus.d_req && !pick_f;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_f = (starve_cnt == 4'(STARVE_LIMIT));

    // Count data grants that overtook a waiting fetch; any other grant resets the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_f) begin
            starve_cnt <= 4'd0;
        end else if (grant_d) begin
            starve_cnt <= fetch_ok ? starve_cnt + 4'd1 : 4'd0;
        end
    end
`else
    assign force_f = 1'b0;
`endif

    // Arbitration FSM: grants a requester, owns the memory handshake, returns the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            drop_q        <= 1'b0;
            bus.f_gnt     <= 1'b0;
            bus.f_rvalid  <= 1'b0;
            bus.f_rdata   <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            bus.f_gnt    <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.f_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= BUSY_D;
                        bus.d_gnt     <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_be    <= bus.d_be;
                    end else if (grant_f) begin
                        state         <= BUSY_F;
                        drop_q        <= 1'b0;
                        bus.f_gnt     <= 1'b1;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.f_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_be    <= BE_ALL;
                    end
                end

                BUSY_F: begin
                    if (bus.f_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        drop_q      <= 1'b0;
                        if (!drop_q && !bus.f_flush) begin
                            bus.f_rvalid <= 1'b1;
                            bus.f_rdata  <= bus.mem_rdata;
                        end
                    end
                end

                BUSY_D: begin
                    if (bus.mem_ack) begin
                        state        <= IDLE;
                        bus.mem_req  <= 1'b0;
                        bus.d_rvalid <= 1'b1;
                        if (!bus.mem_we) begin
                            bus.d_rdata <= bus.mem_rdata;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
